// File: rtl/alarm_trigger.sv
// -----------------------------------------------------------------------------
// alarm_trigger
//
// Compares the stored alarm time against the running clock time. When the
// alarm is armed and the clock enters the matching minute, it starts a ring
// event with a 1 s on / 1 s off buzzer. During the event the stop button
// ends it. The snooze button silences it for SNOOZE_SECONDS ticks, and each
// event allows at most MAX_SNOOZE snoozes. If a ring is not answered within
// RING_SECONDS ticks, the event times out and sets the sticky "missed" flag.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   tick_1hz     in   one-clk strobe per second
//   armed        in   alarm enable (1 = armed)
//   th1..tm0     in   current time, BCD hours tens/units, minutes tens/units
//   ah1..am0     in   alarm time, same encoding
//   push_stop    in   stop button, active-low, debounced
//   push_snooze  in   snooze button, active-low, debounced
//   buzzer       out  registered beep drive
//   ringing      out  high while ringing
//   snoozing     out  high while snoozing
//   missed       out  sticky: last event timed out unanswered
//   snooze_left  out  snoozes remaining in the current event
// -----------------------------------------------------------------------------
module alarm_trigger #(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       armed,
    input  logic [3:0] th1,
    input  logic [3:0] th0,
    input  logic [3:0] tm1,
    input  logic [3:0] tm0,
    input  logic [3:0] ah1,
    input  logic [3:0] ah0,
    input  logic [3:0] am1,
    input  logic [3:0] am0,
    input  logic       push_stop,
    input  logic       push_snooze,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic       missed,
    output logic [3:0] snooze_left
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam logic [9:0] RING_LAST   = 10'(RING_SECONDS - 1);
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECONDS - 1);
    localparam logic [3:0] SNOOZE_LOAD = 4'(MAX_SNOOZE);

    state_t     state_r;
    logic [9:0] sec_cnt_r;
    logic [3:0] snooze_left_r;
    logic       buzzer_r;       // doubles as the beep phase while ringing
    logic       missed_r;
    logic       match_r;
    logic       push_stop_r;
    logic       push_snooze_r;

    logic       match_s;
    logic       trigger_s;
    logic       stop_press_s;
    logic       snooze_press_s;

    assign match_s = (th1 == ah1) && (th0 == ah0) && (tm1 == am1) && (tm0 == am0);

    // Only the rising edge of match starts an event, so arming mid-minute
    // or holding the clock on the alarm minute never retriggers.
    assign trigger_s      = match_s && !match_r && armed;
    assign stop_press_s   = !push_stop && push_stop_r;
    assign snooze_press_s = !push_snooze && push_snooze_r;

    // Alarm event state machine with edge-detect history and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            sec_cnt_r     <= 10'd0;
            snooze_left_r <= 4'd0;
            buzzer_r      <= 1'b0;
            missed_r      <= 1'b0;
            match_r       <= 1'b0;
            push_stop_r   <= 1'b1;
            push_snooze_r <= 1'b1;
        end else begin
            match_r       <= match_s;
            push_stop_r   <= push_stop;
            push_snooze_r <= push_snooze;

            if (!armed) begin
                // Disarming ends any event silently; missed is left as is.
                state_r   <= IDLE;
                sec_cnt_r <= 10'd0;
                buzzer_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (trigger_s) begin
                            state_r       <= RINGING;
                            sec_cnt_r     <= 10'd0;
                            snooze_left_r <= SNOOZE_LOAD;
                            missed_r      <= 1'b0;
                            buzzer_r      <= 1'b1;
                        end else if (stop_press_s) begin
                            missed_r <= 1'b0;
                        end else begin
                            buzzer_r <= 1'b0;
                        end
                    end
                    RINGING: begin
                        if (stop_press_s) begin
                            state_r   <= IDLE;
                            sec_cnt_r <= 10'd0;
                            buzzer_r  <= 1'b0;
                        end else if (snooze_press_s && (snooze_left_r != 4'd0)) begin
                            state_r       <= SNOOZE;
                            snooze_left_r <= snooze_left_r - 4'd1;
                            sec_cnt_r     <= 10'd0;
                            buzzer_r      <= 1'b0;
                        end else if (tick_1hz) begin
                            if (sec_cnt_r == RING_LAST) begin
                                state_r   <= IDLE;
                                sec_cnt_r <= 10'd0;
                                missed_r  <= 1'b1;
                                buzzer_r  <= 1'b0;
                            end else begin
                                sec_cnt_r <= sec_cnt_r + 10'd1;
                                buzzer_r  <= !buzzer_r;
                            end
                        end else begin
                            state_r <= RINGING;
                        end
                    end
                    SNOOZE: begin
                        if (stop_press_s) begin
                            state_r   <= IDLE;
                            sec_cnt_r <= 10'd0;
                            buzzer_r  <= 1'b0;
                        end else if (tick_1hz) begin
                            if (sec_cnt_r == SNOOZE_LAST) begin
                                state_r   <= RINGING;
                                sec_cnt_r <= 10'd0;
                                buzzer_r  <= 1'b1;
                            end else begin
                                sec_cnt_r <= sec_cnt_r + 10'd1;
                            end
                        end else begin
                            state_r <= SNOOZE;
                        end
                    end
                    default: begin
                        state_r   <= IDLE;
                        sec_cnt_r <= 10'd0;
                        buzzer_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign buzzer      = buzzer_r;
    assign ringing     = (state_r == RINGING);
    assign snoozing    = (state_r == SNOOZE);
    assign missed      = missed_r;
    assign snooze_left = snooze_left_r;

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger (RING=4, SNOOZE=3, MAX=2, alarm 07:30).
// Each step drives inputs on the falling edge and pushes the expected
// output vector {buzzer, ringing, snoozing, missed, snooze_left}. After the
// rising edge, it pops that vector and compares it with the DUT outputs.
module tb_alarm_trigger;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic       armed;
    logic [3:0] th1, th0, tm1, tm0;
    logic [3:0] ah1, ah0, am1, am0;
    logic       push_stop, push_snooze;
    logic       buzzer, ringing, snoozing, missed;
    logic [3:0] snooze_left;

    typedef struct {
        string      tag;
        logic [7:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    alarm_trigger #(
        .RING_SECONDS  (4),
        .SNOOZE_SECONDS(3),
        .MAX_SNOOZE    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_1hz   (tick_1hz),
        .armed      (armed),
        .th1        (th1),
        .th0        (th0),
        .tm1        (tm1),
        .tm0        (tm0),
        .ah1        (ah1),
        .ah0        (ah0),
        .am1        (am1),
        .am0        (am0),
        .push_stop  (push_stop),
        .push_snooze(push_snooze),
        .buzzer     (buzzer),
        .ringing    (ringing),
        .snoozing   (snoozing),
        .missed     (missed),
        .snooze_left(snooze_left)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ev(input logic bz, input logic rg, input logic sn,
                                      input logic ms, input logic [3:0] left);
        return {bz, rg, sn, ms, left};
    endfunction

    task automatic set_min(input logic [3:0] m1, input logic [3:0] m0);
        @(negedge clk);
        tm1 = m1;
        tm0 = m0;
    endtask

    // One clock step: drive, queue the expectation, clock it, pop and compare.
    task automatic cyc(input logic t, input logic st_n, input logic sn_n,
                       input logic [7:0] e, input string tag);
        exp_t       x;
        exp_t       y;
        logic [7:0] obs;
        @(negedge clk);
        tick_1hz    = t;
        push_stop   = st_n;
        push_snooze = sn_n;
        x.tag = tag;
        x.v   = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
        y   = sb.pop_front();
        obs = {buzzer, ringing, snoozing, missed, snooze_left};
        total++;
        assert (obs === y.v) else begin
            bad++;
            $error("FAIL %s got=%b expected=%b", y.tag, obs, y.v);
        end
    endtask

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; armed = 1'b1;
        push_stop = 1'b1; push_snooze = 1'b1;
        ah1 = 4'd0; ah0 = 4'd7; am1 = 4'd3; am0 = 4'd0;
        th1 = 4'd0; th0 = 4'd7; tm1 = 4'd2; tm0 = 4'd9;

        cyc(1'b0, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "reset");
        reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "idle");

        // Ring to timeout
        set_min(4'd3, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), "trigger");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 4'd2), "beep_t1");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), "beep_t2");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 4'd2), "beep_t3");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd2), "timeout");
        set_min(4'd3, 4'd1);
        cyc(1'b0, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b1, 4'd2), "missed_sticky");

        // Stop after two ticks, then no retrigger while minute holds
        set_min(4'd3, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), "trigger2");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 4'd2), "r2_t1");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), "r2_t2");
        cyc(1'b0, 1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd2), "stop");
        cyc(1'b0, 1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd2), "stop_held");
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd2), "no_retrigger");
        set_min(4'd3, 4'd1);

        // Snooze twice, third snooze ignored, then stop
        set_min(4'd3, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), "trigger3");
        cyc(1'b0, 1'b1, 1'b0, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "snooze1");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "sn1_t1");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "sn1_t2");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd1), "sn1_end");
        cyc(1'b0, 1'b1, 1'b0, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "snooze2");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "sn2_t1");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd0), "sn2_t2");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd0), "sn2_end");
        cyc(1'b0, 1'b1, 1'b0, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd0), "snooze3_ignored");
        cyc(1'b0, 1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "stop3");
        set_min(4'd3, 4'd1);

        // Arming mid-minute does not ring; disarm during ring
        armed = 1'b0;
        set_min(4'd3, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "disarmed_match");
        armed = 1'b1;
        cyc(1'b0, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "arm_mid_minute");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "arm_mid_minute2");
        set_min(4'd3, 4'd1);
        set_min(4'd3, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), "trigger4");
        armed = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd2), "disarm_ring");
        armed = 1'b1;
        set_min(4'd3, 4'd1);

        // Stop and snooze together; press coincident with tick
        set_min(4'd3, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), "trigger5");
        cyc(1'b0, 1'b0, 1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd2), "stop_and_snooze");
        set_min(4'd3, 4'd1);
        set_min(4'd3, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), "trigger6");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 4'd2), "r6_t1");
        cyc(1'b1, 1'b1, 1'b0, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "snooze_on_tick");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "coinc_t1");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "coinc_t2");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd1), "coinc_ring");
        cyc(1'b1, 1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd1), "stop_on_tick");
        set_min(4'd3, 4'd1);

        // Reset in the middle of a snooze, then a fresh ring
        set_min(4'd3, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), "trigger7");
        cyc(1'b0, 1'b1, 1'b0, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "snooze7");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b1, 1'b0, 4'd1), "sn7_t1");
        reset = 1'b1;
        tm0   = 4'd1;
        cyc(1'b0, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "reset_mid_snooze");
        reset = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 4'd0), "post_reset_idle");
        set_min(4'd3, 4'd0);
        cyc(1'b0, 1'b1, 1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 4'd2), "post_reset_ring");
        cyc(1'b1, 1'b1, 1'b1, ev(1'b0, 1'b1, 1'b0, 1'b0, 4'd2), "post_reset_t1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_trigger.md
# alarm_trigger

Downstream consumer of the alarm-setting stage. Compares the stored alarm time (BCD hours/minutes) against the running clock time and, when armed, raises a beeping buzzer on entry into the matching minute. Provides stop and snooze via the active-low push buttons, a ring timeout, a bounded snooze count and a sticky "missed" flag for the display.

## Interface
- RING_SECONDS, 60: ticks a ring lasts before timing out (1..1023).
- SNOOZE_SECONDS, 300: ticks of silence after a snooze press (1..1023).
- MAX_SNOOZE, 3: snoozes allowed per alarm event (0..15).

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- tick_1hz  in  1  one-clk-wide strobe, once per second.
- armed  in  1  alarm enable switch; 1 = armed.
- th1, th0, tm1, tm0  in  4 each  current time BCD digits (hours tens/units, minutes tens/units).
- ah1, ah0, am1, am0  in  4 each  alarm time BCD digits, same encoding.
- push_stop  in  1  stop button, active-low, already debounced.
- push_snooze  in  1  snooze button, active-low, already debounced.
- buzzer  out  1  beep drive, registered.
- ringing  out  1  high while in RINGING.
- snoozing  out  1  high while in SNOOZE.
- missed  out  1  sticky: last event timed out unanswered.
- snooze_left  out  4  snoozes remaining in the current event.

## Operation
- match = all four digit pairs equal (combinational); match_q = match registered.
- trigger = match & ~match_q & armed (rising edge of match only; arming mid-minute does not ring).
- Button press = falling edge: push_x == 0 and registered push_x_q == 1. push_x_q resets to 1.
- FSM states: IDLE, RINGING, SNOOZE.
  - IDLE: trigger -> RINGING; sec_cnt cleared, snooze_left loaded with MAX_SNOOZE, missed cleared, beep phase = 1. Stop press in IDLE clears missed.
  - RINGING: stop press -> IDLE. Snooze press with snooze_left > 0 -> SNOOZE, snooze_left decrements, sec_cnt cleared. Snooze press with snooze_left == 0 is ignored. tick with sec_cnt == RING_SECONDS-1 -> IDLE, missed set. Other ticks: sec_cnt+1, beep phase toggles.
  - SNOOZE: stop press -> IDLE. tick with sec_cnt == SNOOZE_SECONDS-1 -> RINGING, sec_cnt cleared, beep phase = 1. Snooze press ignored.
- buzzer = 1 only in RINGING with beep phase 1; 0 in all other states.
- ringing/snoozing decode the state register directly.
- sec_cnt is 10 bits; it never exceeds the active parameter minus 1.
- Priority in one cycle: reset > armed == 0 > stop press > snooze press > tick.
- armed == 0 in any state -> IDLE next edge, buzzer 0; missed unchanged.
- Alarm or clock digits changing during RINGING/SNOOZE do not affect the event; only match edges in IDLE start a new one.

## Timing
- Reset: state IDLE, buzzer 0, ringing 0, snoozing 0, missed 0, snooze_left 0, sec_cnt 0, match_q 0, push_stop_q 1, push_snooze_q 1, beep phase 0.
- Trigger latency: match rises sampled at edge N -> ringing = 1, buzzer = 1 after edge N.
- Button latency: first low sample at edge N -> new state visible after edge N. A held button acts once.
- Ring length: exactly RING_SECONDS tick strobes after entry; timeout tick is the RING_SECONDS-th.
- Beep: buzzer toggles on each non-final tick in RINGING (1 s on, 1 s off).
- Tick and press on the same edge: press wins; the tick is not counted.

## Test plan
- RING_SECONDS=4, SNOOZE=3, MAX=2; alarm 07:30, clock steps 07:29 -> 07:30, armed=1 -> ringing and buzzer 1 next cycle; buzzer 1,0,1,0 across ticks; 4th tick -> IDLE, missed=1, buzzer 0.
- Same setup, stop press after 2 ticks -> IDLE next cycle, missed=0; clock held at 07:30 for 10 ticks -> no retrigger.
- Snooze twice: each press -> snoozing=1, snooze_left 2->1->0; after 3 ticks -> ringing again with buzzer 1; third snooze press ignored; stop -> IDLE.
- armed switched 0->1 while clock already at 07:30 -> no ring; armed=0 during RINGING -> IDLE next cycle, buzzer 0.
- Stop and snooze pressed same cycle in RINGING -> IDLE, snooze_left unchanged; press coincident with tick -> sec_cnt not incremented.
- reset asserted mid-SNOOZE -> all outputs at reset values after next edge; after release, next match edge rings normally.
